// File: rtl/sram_arb_ctrl.sv
// Round-robin write/read arbiter and timing controller for a 256K x 16
// asynchronous SRAM. Every SRAM-side output comes straight from a flop.
module sram_arb_ctrl #(
  parameter int unsigned WR_CYC = 2,
  parameter int unsigned RD_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_REQ,
  input  logic [17:0] WR_ADDR,
  input  logic [15:0] WR_DATA,
  input  logic [1:0]  WR_BE,
  output logic        WR_ACK,
  input  logic        RD_REQ,
  input  logic [17:0] RD_ADDR,
  output logic        RD_ACK,
  output logic [15:0] RD_DATA,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DATA,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned AW      = 18;
  localparam int unsigned DW      = 16;
  localparam int unsigned BW      = 2;
  localparam int unsigned MAX_CYC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_STROBE,
    S_RD_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_wr_q, last_wr_d;
  logic              grant_wr, grant_rd;

  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [BW-1:0]     be_q, be_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              drv_q, drv_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;

  // State, phase counter and arbitration history
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Next state: alternate on contention, time PULSE/STROBE with cnt
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    grant_wr  = WR_REQ && (!RD_REQ || !last_wr_q);
    grant_rd  = RD_REQ && !grant_wr;
    case (state_q)
      S_IDLE: begin
        if (grant_wr) begin
          state_d   = S_WR_SETUP;
          last_wr_d = 1'b1;
        end else if (grant_rd) begin
          state_d   = S_RD_STROBE;
          cnt_d     = '0;
          last_wr_d = 1'b0;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = '0;
      end
      S_WR_PULSE: begin
        if (cnt_q == CNT_W'(WR_CYC - 1)) state_d = S_WR_HOLD;
        else                             cnt_d   = CNT_W'(cnt_q + 1'b1);
      end
      S_WR_HOLD:   state_d = S_IDLE;
      S_RD_STROBE: begin
        if (cnt_q == CNT_W'(RD_CYC - 1)) state_d = S_RD_DONE;
        else                             cnt_d   = CNT_W'(cnt_q + 1'b1);
      end
      S_RD_DONE:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs for the upcoming state, plus request latching and read capture
  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    rd_data_d = rd_data_q;
    drv_d     = 1'b0;
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    ub_n_d    = 1'b1;
    lb_n_d    = 1'b1;
    wr_ack_d  = 1'b0;
    rd_ack_d  = 1'b0;
    if (state_q == S_IDLE && grant_wr) begin
      addr_d = WR_ADDR;
      data_d = WR_DATA;
      be_d   = WR_BE;
    end else if (state_q == S_IDLE && grant_rd) begin
      addr_d = RD_ADDR;
    end
    // Data is captured on the edge that ends the last strobe cycle
    if (state_q == S_RD_STROBE && state_d == S_RD_DONE) rd_data_d = SRAM_DATA;
    case (state_d)
      S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
        ce_n_d   = 1'b0;
        ub_n_d   = ~be_d[1];
        lb_n_d   = ~be_d[0];
        we_n_d   = (state_d != S_WR_PULSE);
        drv_d    = (state_d != S_WR_SETUP);
        wr_ack_d = (state_d == S_WR_HOLD);
      end
      S_RD_STROBE: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
      S_RD_DONE: rd_ack_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath and SRAM-side output registers; reset releases the bus at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      rd_data_q <= '0;
      drv_q     <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      rd_data_q <= rd_data_d;
      drv_q     <= drv_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
    end
  end

  assign SRAM_DATA = drv_q ? data_q : {DW{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign WR_ACK    = wr_ack_q;
  assign RD_ACK    = rd_ack_q;
  assign RD_DATA   = rd_data_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl: default-timing instance (a) and a
// WR_CYC=1 / RD_CYC=4 instance (b), each attached to its own SRAM model.
module tb_sram_arb_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_wr_req, a_rd_req, a_wr_ack, a_rd_ack;
  logic [17:0] a_wr_addr, a_rd_addr, a_sram_addr;
  logic [15:0] a_wr_data, a_rd_data;
  logic [1:0]  a_wr_be;
  logic        a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n;
  tri1  [15:0] a_sram_data;

  logic        b_wr_req, b_rd_req, b_wr_ack, b_rd_ack;
  logic [17:0] b_wr_addr, b_rd_addr, b_sram_addr;
  logic [15:0] b_wr_data, b_rd_data;
  logic [1:0]  b_wr_be;
  logic        b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;
  tri1  [15:0] b_sram_data;

  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];

  sram_arb_ctrl u_a (
    .CLK(clk), .RST(rst),
    .WR_REQ(a_wr_req), .WR_ADDR(a_wr_addr), .WR_DATA(a_wr_data), .WR_BE(a_wr_be), .WR_ACK(a_wr_ack),
    .RD_REQ(a_rd_req), .RD_ADDR(a_rd_addr), .RD_ACK(a_rd_ack), .RD_DATA(a_rd_data),
    .SRAM_ADDR(a_sram_addr), .SRAM_DATA(a_sram_data), .SRAM_CE_N(a_ce_n), .SRAM_OE_N(a_oe_n),
    .SRAM_WE_N(a_we_n), .SRAM_UB_N(a_ub_n), .SRAM_LB_N(a_lb_n)
  );

  sram_arb_ctrl #(.WR_CYC(1), .RD_CYC(4)) u_b (
    .CLK(clk), .RST(rst),
    .WR_REQ(b_wr_req), .WR_ADDR(b_wr_addr), .WR_DATA(b_wr_data), .WR_BE(b_wr_be), .WR_ACK(b_wr_ack),
    .RD_REQ(b_rd_req), .RD_ADDR(b_rd_addr), .RD_ACK(b_rd_ack), .RD_DATA(b_rd_data),
    .SRAM_ADDR(b_sram_addr), .SRAM_DATA(b_sram_data), .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n),
    .SRAM_WE_N(b_we_n), .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n)
  );

  // SRAM models: drive the bus while OE_N is low, write masked bytes while WE_N is low
  assign a_sram_data = (!a_ce_n && !a_oe_n) ? mem_a[a_sram_addr] : 16'hzzzz;
  assign b_sram_data = (!b_ce_n && !b_oe_n) ? mem_b[b_sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!a_ce_n && !a_we_n) begin
      if (!a_ub_n) mem_a[a_sram_addr][15:8] <= a_sram_data[15:8];
      if (!a_lb_n) mem_a[a_sram_addr][7:0]  <= a_sram_data[7:0];
    end
    if (!b_ce_n && !b_we_n) begin
      if (!b_ub_n) mem_b[b_sram_addr][15:8] <= b_sram_data[15:8];
      if (!b_lb_n) mem_b[b_sram_addr][7:0]  <= b_sram_data[7:0];
    end
  end

  // Every cycle: no WE_N/OE_N overlap, and during reads the bus carries only the SRAM word
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if ((!a_we_n && !a_oe_n) || (!b_we_n && !b_oe_n)) begin
          errors++;
          $display("FAIL we_oe_overlap: a we/oe=%b%b b we/oe=%b%b required never both 0",
                   a_we_n, a_oe_n, b_we_n, b_oe_n);
        end
        if (!a_oe_n) begin
          checks++;
          if (a_sram_data !== mem_a[a_sram_addr]) begin
            errors++;
            $display("FAIL read_bus_a: actual %h required %h", a_sram_data, mem_a[a_sram_addr]);
          end
        end
        if (!b_oe_n) begin
          checks++;
          if (b_sram_data !== mem_b[b_sram_addr]) begin
            errors++;
            $display("FAIL read_bus_b: actual %h required %h", b_sram_data, mem_b[b_sram_addr]);
          end
        end
      end
    end
  endtask

  // Issue one write from an IDLE cycle and measure it; ends in the following IDLE cycle
  task automatic do_write(input bit b, input logic [17:0] a, input logic [15:0] d, input logic [1:0] be,
                          output int lat, output int pulse, output logic [1:0] ublb,
                          output logic [15:0] setup_bus, output bit addr_ok);
    lat = -1; pulse = 0; ublb = 2'b11; setup_bus = '0; addr_ok = 1'b1;
    if (b) begin b_wr_addr = a; b_wr_data = d; b_wr_be = be; b_wr_req = 1'b1; end
    else   begin a_wr_addr = a; a_wr_data = d; a_wr_be = be; a_wr_req = 1'b1; end
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) setup_bus = b ? b_sram_data : a_sram_data;
      if (!(b ? b_we_n : a_we_n)) begin
        pulse++;
        ublb = b ? {b_ub_n, b_lb_n} : {a_ub_n, a_lb_n};
        if ((b ? b_sram_addr : a_sram_addr) !== a) addr_ok = 1'b0;
      end
      if (b ? b_wr_ack : a_wr_ack) lat = k;
    end
    if (b) b_wr_req = 1'b0; else a_wr_req = 1'b0;
    @(negedge clk);
  endtask

  // Issue one read from an IDLE cycle and measure it; ends in the following IDLE cycle
  task automatic do_read(input bit b, input logic [17:0] a,
                         output int lat, output int strobe, output logic [15:0] data);
    lat = -1; strobe = 0; data = '0;
    if (b) begin b_rd_addr = a; b_rd_req = 1'b1; end
    else   begin a_rd_addr = a; a_rd_req = 1'b1; end
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (!(b ? b_oe_n : a_oe_n)) strobe++;
      if (b ? b_rd_ack : a_rd_ack) begin lat = k; data = b ? b_rd_data : a_rd_data; end
    end
    if (b) b_rd_req = 1'b0; else a_rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n, b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n} !== 10'h3FF) begin
      errors++;
      $display("FAIL reset_strobes: a=%b%b%b%b%b b=%b%b%b%b%b required all 1",
               a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n, b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n);
    end
    checks++;
    if ({a_wr_ack, a_rd_ack, a_sram_addr, a_rd_data} !== 36'h0) begin
      errors++;
      $display("FAIL reset_values: acks=%b%b addr=%h rd_data=%h required 0", a_wr_ack, a_rd_ack,
               a_sram_addr, a_rd_data);
    end
    checks++;
    if (a_sram_data !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_bus: actual %h required %h (released)", a_sram_data, 16'hFFFF);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int lat, pulse; logic [1:0] ublb; logic [15:0] sb; bit aok;
    do_write(1'b0, 18'h00010, 16'hA55A, 2'b11, lat, pulse, ublb, sb, aok);
    checks++; if (lat !== 4)  begin errors++; $display("FAIL wr_latency: actual %0d required 4", lat); end
    checks++; if (pulse !== 2) begin errors++; $display("FAIL wr_pulse: actual %0d required 2", pulse); end
    checks++; if (ublb !== 2'b00) begin errors++; $display("FAIL wr_ublb: actual %b required 00", ublb); end
    checks++; if (sb !== 16'hFFFF) begin errors++; $display("FAIL wr_setup_bus: actual %h required FFFF", sb); end
    checks++; if (!aok) begin errors++; $display("FAIL wr_addr: actual wrong required 00010 during pulse"); end
    checks++;
    if (mem_a[18'h00010] !== 16'hA55A) begin
      errors++; $display("FAIL wr_mem: actual %h required A55A", mem_a[18'h00010]);
    end
  endtask

  task automatic test_readback();
    int lat, strobe; logic [15:0] d;
    do_read(1'b0, 18'h00010, lat, strobe, d);
    checks++; if (lat !== 3)    begin errors++; $display("FAIL rd_latency: actual %0d required 3", lat); end
    checks++; if (strobe !== 2) begin errors++; $display("FAIL rd_strobe: actual %0d required 2", strobe); end
    checks++; if (d !== 16'hA55A) begin errors++; $display("FAIL rd_data: actual %h required A55A", d); end
    @(negedge clk);
    checks++;
    if (a_rd_data !== 16'hA55A) begin errors++; $display("FAIL rd_data_hold: actual %h required A55A", a_rd_data); end
  endtask

  task automatic test_byte_write();
    int lat, pulse, strobe; logic [1:0] ublb; logic [15:0] sb, d; bit aok;
    do_write(1'b0, 18'h00010, 16'h1234, 2'b01, lat, pulse, ublb, sb, aok);
    checks++; if (ublb !== 2'b10) begin errors++; $display("FAIL byte_ublb: actual %b required 10", ublb); end
    do_read(1'b0, 18'h00010, lat, strobe, d);
    checks++; if (d !== 16'hA534) begin errors++; $display("FAIL byte_merge: actual %h required A534", d); end
  endtask

  task automatic test_boundary();
    int lat, pulse, strobe; logic [1:0] ublb; logic [15:0] sb, d; bit aok;
    do_write(1'b0, 18'h3FFFF, 16'hFFFF, 2'b11, lat, pulse, ublb, sb, aok);
    checks++; if (!aok) begin errors++; $display("FAIL top_addr: actual wrong required 3FFFF during pulse"); end
    do_write(1'b0, 18'h00000, 16'h0001, 2'b11, lat, pulse, ublb, sb, aok);
    do_read(1'b0, 18'h3FFFF, lat, strobe, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL rd_top: actual %h required FFFF", d); end
    do_read(1'b0, 18'h00000, lat, strobe, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rd_zero: actual %h required 0001", d); end
  endtask

  // Both requests held from reset: W, R, W, R with one IDLE cycle between transactions
  task automatic test_back_to_back();
    string seq; int cyc[4]; logic [15:0] rv[2]; int n, nr;
    seq = ""; n = 0; nr = 0;
    rst = 1'b1;
    a_wr_addr = 18'h00100; a_wr_data = 16'h7E7E; a_wr_be = 2'b11; a_rd_addr = 18'h00100;
    a_wr_req = 1'b1; a_rd_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (a_wr_ack) begin seq = {seq, "W"}; cyc[n] = k; n++; end
      if (a_rd_ack) begin seq = {seq, "R"}; cyc[n] = k; n++; if (nr < 2) rv[nr] = a_rd_data; nr++; end
    end
    a_wr_req = 1'b0; a_rd_req = 1'b0;
    @(negedge clk);
    checks++; if (seq != "WRWR") begin errors++; $display("FAIL grant_order: actual %s required WRWR", seq); end
    if (n == 4) begin
      checks++;
      if (cyc[0] != 4 || cyc[1] - cyc[0] != 4 || cyc[2] - cyc[1] != 5 || cyc[3] - cyc[2] != 4) begin
        errors++;
        $display("FAIL b2b_spacing: actual acks at %0d,%0d,%0d,%0d required 4,8,13,17", cyc[0], cyc[1], cyc[2], cyc[3]);
      end
    end
    if (nr == 2) begin
      checks++;
      if (rv[0] !== 16'h7E7E || rv[1] !== 16'h7E7E) begin
        errors++; $display("FAIL b2b_rdata: actual %h %h required 7E7E 7E7E", rv[0], rv[1]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen; int lat, pulse, strobe; logic [1:0] ublb; logic [15:0] sb, d; bit aok;
    seen = 1'b0;
    a_wr_addr = 18'h00200; a_wr_data = 16'h5A5A; a_wr_be = 2'b11; a_wr_req = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (!a_we_n) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_pulse_seen: actual no pulse required pulse"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n} !== 5'b11111) begin
      errors++; $display("FAIL mid_rst_strobes: actual %b%b%b%b%b required 11111", a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n);
    end
    checks++; if (a_sram_data !== 16'hFFFF) begin errors++; $display("FAIL mid_rst_bus: actual %h required FFFF", a_sram_data); end
    a_wr_req = 1'b0;
    @(negedge clk);
    checks++; if (a_wr_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_ack: actual %b required 0", a_wr_ack); end
    rst = 1'b0;
    @(negedge clk);
    do_write(1'b0, 18'h00200, 16'h6C6C, 2'b11, lat, pulse, ublb, sb, aok);
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_rst_wr: actual latency %0d required 4", lat); end
    do_read(1'b0, 18'h00200, lat, strobe, d);
    checks++; if (d !== 16'h6C6C) begin errors++; $display("FAIL post_rst_rd: actual %h required 6C6C", d); end
  endtask

  task automatic test_timing_sweep();
    int lat, pulse, strobe; logic [1:0] ublb; logic [15:0] sb, d; bit aok;
    do_write(1'b1, 18'h2AAAA, 16'hC3C3, 2'b11, lat, pulse, ublb, sb, aok);
    checks++; if (lat !== 3)   begin errors++; $display("FAIL sweep_wr_latency: actual %0d required 3", lat); end
    checks++; if (pulse !== 1) begin errors++; $display("FAIL sweep_wr_pulse: actual %0d required 1", pulse); end
    do_read(1'b1, 18'h2AAAA, lat, strobe, d);
    checks++; if (lat !== 5)    begin errors++; $display("FAIL sweep_rd_latency: actual %0d required 5", lat); end
    checks++; if (strobe !== 4) begin errors++; $display("FAIL sweep_rd_strobe: actual %0d required 4", strobe); end
    checks++; if (d !== 16'hC3C3) begin errors++; $display("FAIL sweep_rd_data: actual %h required C3C3", d); end
  endtask

  initial begin
    rst = 1'b1;
    a_wr_req = 1'b0; a_rd_req = 1'b0; a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0; a_wr_be = '0;
    b_wr_req = 1'b0; b_rd_req = 1'b0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0; b_wr_be = '0;
    fork monitor(); join_none
    test_reset();
    test_single_write();
    test_readback();
    test_byte_write();
    test_boundary();
    test_back_to_back();
    test_reset_mid_write();
    test_timing_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
